// File: rtl/pe_elem_sequencer.sv
// pe_elem_sequencer
//   Steps one pe_32b datapath through the elements of a single vector
//   instruction. A descriptor is accepted from decode/issue; then one element
//   per cycle is issued as a vector-register-file read. One cycle later the PE
//   enable and the write-back request are raised with the destination
//   element's byte offset.
//
//   Optional feature macro: PE_SEQ_PERF_EN (adds perf_elems / perf_stalls).
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   instr_*           descriptor handshake and fields (vl, vsew, widening, vs1, vs2, vd)
//   rd_en             register-file read request (data returns next cycle)
//   rd_vs1/vs2/vd     latched register indices
//   rd_byte_off       source element byte offset  (idx << vsew)
//   stall             read port unavailable this cycle
//   pe_en, wr_en      PE inputs valid / write-back request (same signal)
//   wr_vreg           destination register
//   wr_byte_off       destination element byte offset (idx << deew)
//   wr_eew            destination element width
//   busy, done, err   descriptor in flight / completion pulse / illegal-descriptor pulse
//   perf_elems        (PE_SEQ_PERF_EN) saturating count of wr_en cycles
//   perf_stalls       (PE_SEQ_PERF_EN) saturating count of stalled RUN cycles
module pe_elem_sequencer #(
    parameter  int VLEN   = 128,
    localparam int ELEM_W = $clog2(VLEN / 8) + 1,
    localparam int OFF_W  = $clog2(VLEN / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ELEM_W-1:0] instr_vl,
    input  logic [1:0]        instr_vsew,
    input  logic [1:0]        instr_widening,
    input  logic [4:0]        instr_vs1,
    input  logic [4:0]        instr_vs2,
    input  logic [4:0]        instr_vd,
    output logic              rd_en,
    output logic [4:0]        rd_vs1,
    output logic [4:0]        rd_vs2,
    output logic [4:0]        rd_vd,
    output logic [OFF_W-1:0]  rd_byte_off,
    input  logic              stall,
    output logic              pe_en,
    output logic              wr_en,
    output logic [4:0]        wr_vreg,
    output logic [OFF_W-1:0]  wr_byte_off,
    output logic [1:0]        wr_eew,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_elems,
    output logic [15:0]       perf_stalls
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    // Elements of the narrowest (8-bit) width that fit in one register.
    localparam logic [ELEM_W-1:0] MAX_ELEMS = ELEM_W'(VLEN / 8);

    state_t state, state_next;

    logic              accept;
    logic [2:0]        deew_in;
    logic              illegal_in;
    logic [ELEM_W-1:0] cap_in;
    logic [ELEM_W-1:0] n_in;

    logic [4:0]        vs1_q, vs2_q, vd_q;
    logic [1:0]        vsew_q, deew_q;
    logic [ELEM_W-1:0] n_q;
    logic [ELEM_W-1:0] idx;
    logic              err_q;
    logic              last_elem;

    logic              s1_valid;
    logic [OFF_W-1:0]  s1_idx;

    // Descriptor decode, evaluated on the raw inputs so it can be latched on accept.
    assign accept     = instr_valid & instr_ready;
    assign deew_in    = {1'b0, instr_vsew} + {1'b0, instr_widening};
    assign illegal_in = (instr_vsew == 2'd3) || (instr_widening == 2'd3) || (deew_in > 3'd2);
    // Clamp to the number of destination elements that fit in one register;
    // this is what keeps wr_byte_off from overflowing.
    assign cap_in     = MAX_ELEMS >> deew_in[1:0];
    assign n_in       = (instr_vl < cap_in) ? instr_vl : cap_in;

    assign last_elem  = (idx == n_q - ELEM_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        rd_en       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (accept) begin
                    state_next = (illegal_in || n_in == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                rd_en = ~stall;
                if (!stall && last_elem) state_next = DRAIN;
            end
            DRAIN: state_next = FIN;   // final write-back happens this cycle
            FIN: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            vsew_q   <= '0;
            deew_q   <= '0;
            n_q      <= '0;
            idx      <= '0;
            err_q    <= 1'b0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else begin
            // Read-to-write pipeline stage; writes are never stalled.
            s1_valid <= rd_en;
            s1_idx   <= idx[OFF_W-1:0];
            if (accept) begin
                vs1_q  <= instr_vs1;
                vs2_q  <= instr_vs2;
                vd_q   <= instr_vd;
                vsew_q <= instr_vsew;
                deew_q <= deew_in[1:0];
                n_q    <= illegal_in ? '0 : n_in;
                err_q  <= illegal_in;
                idx    <= '0;
            end else if (rd_en) begin
                idx <= idx + ELEM_W'(1);
            end
        end
    end

    assign rd_vs1      = vs1_q;
    assign rd_vs2      = vs2_q;
    assign rd_vd       = vd_q;
    assign rd_byte_off = idx[OFF_W-1:0] << vsew_q;

    assign wr_en       = s1_valid;
    assign pe_en       = s1_valid;
    assign wr_vreg     = vd_q;
    assign wr_eew      = deew_q;
    assign wr_byte_off = s1_idx << deew_q;

`ifdef PE_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_elems  <= '0;
            perf_stalls <= '0;
        end else if (accept) begin
            perf_elems  <= '0;
            perf_stalls <= '0;
        end else begin
            if (wr_en && perf_elems != 16'hFFFF)
                perf_elems <= perf_elems + 16'd1;
            if (state == RUN && stall && perf_stalls != 16'hFFFF)
                perf_stalls <= perf_stalls + 16'd1;
        end
    end
`else
    // Default build: no performance counters.
`endif

endmodule

// File: tb/tb_pe_elem_sequencer.sv
// tb_pe_elem_sequencer
//   Directed-vector scoreboard bench for pe_elem_sequencer (VLEN=128).
//   Stimulus pushes hand-computed expected reads, writes and completions
//   (with their absolute cycle numbers) into queues; a monitor on the falling
//   edge pops and compares whenever the DUT presents rd_en, wr_en or done.
module tb_pe_elem_sequencer;

    localparam int VLEN   = 128;
    localparam int ELEM_W = 5;
    localparam int OFF_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [ELEM_W-1:0] instr_vl = '0;
    logic [1:0]        instr_vsew = '0;
    logic [1:0]        instr_widening = '0;
    logic [4:0]        instr_vs1 = '0;
    logic [4:0]        instr_vs2 = '0;
    logic [4:0]        instr_vd = '0;
    logic              rd_en;
    logic [4:0]        rd_vs1, rd_vs2, rd_vd;
    logic [OFF_W-1:0]  rd_byte_off;
    logic              stall = 1'b0;
    logic              pe_en, wr_en;
    logic [4:0]        wr_vreg;
    logic [OFF_W-1:0]  wr_byte_off;
    logic [1:0]        wr_eew;
    logic              busy, done, err;
`ifdef PE_SEQ_PERF_EN
    logic [15:0]       perf_elems, perf_stalls;
`endif

    pe_elem_sequencer #(.VLEN(VLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_vl       (instr_vl),
        .instr_vsew     (instr_vsew),
        .instr_widening (instr_widening),
        .instr_vs1      (instr_vs1),
        .instr_vs2      (instr_vs2),
        .instr_vd       (instr_vd),
        .rd_en          (rd_en),
        .rd_vs1         (rd_vs1),
        .rd_vs2         (rd_vs2),
        .rd_vd          (rd_vd),
        .rd_byte_off    (rd_byte_off),
        .stall          (stall),
        .pe_en          (pe_en),
        .wr_en          (wr_en),
        .wr_vreg        (wr_vreg),
        .wr_byte_off    (wr_byte_off),
        .wr_eew         (wr_eew),
        .busy           (busy),
        .done           (done),
        .err            (err)
`ifdef PE_SEQ_PERF_EN
        ,
        .perf_elems     (perf_elems),
        .perf_stalls    (perf_stalls)
`endif
    );

    typedef struct {
        int cyc;
        int off;
        int aux;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    exp_t done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    int st_lo  = 1000;
    int st_hi  = -1;
    logic [4:0] cur_vs1, cur_vs2, cur_vd;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stall window, relative to the accept cycle of the current descriptor.
    always @(posedge clk) begin
        #2;
        stall = ((cyc - base) >= st_lo) && ((cyc - base) <= st_hi);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic push_rd(input int rel, input int off);
        exp_t e;
        e.cyc = base + rel;
        e.off = off;
        e.aux = int'({cur_vs1, cur_vs2, cur_vd});
        rd_q.push_back(e);
    endtask

    task automatic push_wr(input int rel, input int off, input int eew);
        exp_t e;
        e.cyc = base + rel;
        e.off = off;
        e.aux = int'({cur_vd, eew[1:0]});
        wr_q.push_back(e);
    endtask

    task automatic push_done(input int rel, input int err_exp);
        exp_t e;
        e.cyc = base + rel;
        e.off = 0;
        e.aux = err_exp;
        done_q.push_back(e);
    endtask

    // Monitor: compares DUT transactions against the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc - base, e.cyc - base);
                    check("rd_byte_off", 32'(rd_byte_off), e.off);
                    check("rd_regs", 32'({rd_vs1, rd_vs2, rd_vd}), e.aux);
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc - base, e.cyc - base);
                    check("wr_byte_off", 32'(wr_byte_off), e.off);
                    check("wr_vreg_eew", 32'({wr_vreg, wr_eew}), e.aux);
                    check("pe_en", 32'(pe_en), 32'd1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc - base, e.cyc - base);
                    check("done_err", 32'(err), e.aux);
                    check("done_busy", 32'(busy), 32'd1);
                end
            end
            if (err && !done) check("err_without_done", 32'(err), 32'd0);
        end
    end

    // Waits (bounded) for instr_ready, then presents a descriptor; returns in cycle 0.
    task automatic start(input int vl, input int vsew, input int wid, input int vd);
        @(posedge clk); #1;
        for (int i = 0; i < 64 && !instr_ready; i++) begin
            @(posedge clk); #1;
        end
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        base           = cyc;
        cur_vs1        = 5'd1;
        cur_vs2        = 5'd2;
        cur_vd         = vd[4:0];
        instr_vl       = vl[ELEM_W-1:0];
        instr_vsew     = vsew[1:0];
        instr_widening = wid[1:0];
        instr_vs1      = cur_vs1;
        instr_vs2      = cur_vs2;
        instr_vd       = cur_vd;
        instr_valid    = 1'b1;
    endtask

    // Drops instr_valid, optionally pokes a descriptor while busy, then runs
    // to cycle len+1 and confirms every expectation was consumed.
    task automatic finish(input int len, input bit poke);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (poke) begin
            @(posedge clk); #1;
            instr_valid = 1'b1;
            instr_vl    = 5'd1;
            instr_vd    = 5'd31;
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
        while (cyc < base + len + 1) begin
            @(posedge clk); #1;
        end
        check("pending_rd", rd_q.size(), 0);
        check("pending_wr", wr_q.size(), 0);
        check("pending_done", done_q.size(), 0);
        st_lo = 1000;
        st_hi = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_instr_ready", 32'(instr_ready), 32'd1);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // vl=4, 8-bit, no widening
        start(4, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            push_rd(1 + i, i);
            push_wr(2 + i, i, 0);
        end
        push_done(6, 0);
        finish(6, 0);

        // vl=3, 16-bit source widened to 32-bit
        start(3, 1, 1, 5);
        push_rd(1, 0); push_rd(2, 2); push_rd(3, 4);
        push_wr(2, 0, 2); push_wr(3, 4, 2); push_wr(4, 8, 2);
        push_done(5, 0);
        finish(5, 0);

        // vl=20 quad widen: clamped to 4 elements
        start(20, 0, 2, 7);
        push_rd(1, 0); push_rd(2, 1); push_rd(3, 2); push_rd(4, 3);
        push_wr(2, 0, 2); push_wr(3, 4, 2); push_wr(4, 8, 2); push_wr(5, 12, 2);
        push_done(6, 0);
        finish(6, 0);

        // vl=4 with stall in cycles 2-3
        start(4, 0, 0, 6);
        st_lo = 2;
        st_hi = 3;
        push_rd(1, 0); push_rd(4, 1); push_rd(5, 2); push_rd(6, 3);
        push_wr(2, 0, 0); push_wr(5, 1, 0); push_wr(6, 2, 0); push_wr(7, 3, 0);
        push_done(8, 0);
        finish(8, 0);
`ifdef PE_SEQ_PERF_EN
        check("perf_stalls", 32'(perf_stalls), 32'd2);
        check("perf_elems", 32'(perf_elems), 32'd4);
`endif

        // Illegal: deew = 3
        start(4, 2, 1, 4);
        push_done(1, 1);
        finish(1, 0);
        check("illegal_ready_after_done", 32'(instr_ready), 32'd1);

        // Illegal: vsew = 3
        start(2, 3, 0, 4);
        push_done(1, 1);
        finish(1, 0);

        // Illegal: widening = 3
        start(2, 0, 3, 4);
        push_done(1, 1);
        finish(1, 0);

        // vl=0: straight to completion, no error
        start(0, 0, 0, 8);
        push_done(1, 0);
        finish(1, 0);

        // vl=16: largest 8-bit count
        start(16, 0, 0, 10);
        for (int i = 0; i < 16; i++) begin
            push_rd(1 + i, i);
            push_wr(2 + i, i, 0);
        end
        push_done(18, 0);
        finish(18, 0);

        // vl=5 at 32-bit clamps to 4; a descriptor offered while busy is ignored
        start(5, 2, 0, 12);
        push_rd(1, 0); push_rd(2, 4); push_rd(3, 8); push_rd(4, 12);
        push_wr(2, 0, 2); push_wr(3, 4, 2); push_wr(4, 8, 2); push_wr(5, 12, 2);
        push_done(6, 0);
        finish(6, 1);

        // Reset in cycle 3 of a vl=8 run
        start(8, 0, 0, 9);
        push_rd(1, 0); push_rd(2, 1);
        push_wr(2, 0, 0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_rd_en", 32'(rd_en), 32'd0);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_pe_en", 32'(pe_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_instr_ready", 32'(instr_ready), 32'd1);
        check("midrst_rd_byte_off", 32'(rd_byte_off), 32'd0);
        check("midrst_wr_byte_off", 32'(wr_byte_off), 32'd0);
        check("midrst_rd_vd", 32'(rd_vd), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_pending_rd", rd_q.size(), 0);
        check("midrst_pending_wr", wr_q.size(), 0);

        // vl=1 after reset completes normally
        start(1, 0, 0, 2);
        push_rd(1, 0);
        push_wr(2, 0, 0);
        push_done(3, 0);
        finish(3, 0);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
